// File: rtl/clint_trap_ctrl_pkg.sv
// Shared constants for the core-local trap sequencer: instruction encodings,
// CSR addresses, trap causes, mstatus bit positions and the sequencer state
// encoding. Helper functions compute the mstatus images written on entry/mret.
package clint_trap_ctrl_pkg;

   localparam int RegBus     = 32;
   localparam int MemAddrBus = 32;
   localparam int InstBus    = 32;

   // Instruction encodings recognised at the decode/execute boundary
   localparam logic [InstBus-1:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [InstBus-1:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [InstBus-1:0] INST_MRET   = 32'h3020_0073;

   // Machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   // mcause values
   localparam logic [RegBus-1:0] CAUSE_ECALL  = 32'd11;
   localparam logic [RegBus-1:0] CAUSE_EBREAK = 32'd3;
   localparam logic [RegBus-1:0] CAUSE_TIMER  = 32'h8000_0004;

   // mstatus bit indices
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_MEPC,
      S_W_MSTATUS,
      S_W_MCAUSE,
      S_ASSERT,
      S_MRET_MSTATUS,
      S_MRET_ASSERT
   } state_e;

   // Trap entry: stash MIE into MPIE and disable interrupts
   function automatic logic [RegBus-1:0] trap_mstatus(input logic [RegBus-1:0] m);
      logic [RegBus-1:0] r;
      r               = m;
      r[MSTATUS_MPIE] = m[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // mret: restore MIE from MPIE
   function automatic logic [RegBus-1:0] mret_mstatus(input logic [RegBus-1:0] m);
      logic [RegBus-1:0] r;
      r              = m;
      r[MSTATUS_MIE] = m[MSTATUS_MPIE];
      return r;
   endfunction

endpackage

// File: rtl/clint_trap_ctrl_if.sv
// Bundle of pipeline, CSR-read and CSR-write/redirect signals around the trap
// sequencer. slave = the sequencer itself; master = pipeline + CSR file side.
// Pure wiring, no timing of its own.
interface clint_trap_ctrl_if;
   import clint_trap_ctrl_pkg::*;

   // pipeline / CSR file -> sequencer
   logic                    int_flag_i;
   logic [InstBus-1:0]      inst_i;
   logic [MemAddrBus-1:0]   inst_addr_i;
   logic                    jump_flag_i;
   logic [MemAddrBus-1:0]   jump_addr_i;
   logic                    div_started_i;
   logic [RegBus-1:0]       csr_mtvec_i;
   logic [RegBus-1:0]       csr_mepc_i;
   logic [RegBus-1:0]       csr_mstatus_i;
   logic                    global_int_en_i;

   // sequencer -> pipeline / CSR file
   logic                    hold_flag_o;
   logic                    we_o;
   logic [MemAddrBus-1:0]   waddr_o;
   logic [RegBus-1:0]       data_o;
   logic                    int_assert_o;
   logic [MemAddrBus-1:0]   int_addr_o;

   modport slave (
      input  int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
             div_started_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
      output hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o
   );

   modport master (
      output int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
             div_started_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
      input  hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o
   );

endinterface

// File: rtl/clint_trap_ctrl.sv
// Trap sequencer: detects ecall/ebreak/mret/timer irq, writes mepc/mstatus/mcause, redirects PC.
// Latency: entry writes N+1..N+3, redirect N+4; mret writes N+1, redirect N+2.
// Backpressure: hold_flag_o stalls the pipeline from the trigger cycle until the redirect cycle.
module clint_trap_ctrl
   import clint_trap_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   clint_trap_ctrl_if.slave        bus
);

   state_e                 state_q, state_d;
   logic [RegBus-1:0]      cause_q, cause_d;
   logic [MemAddrBus-1:0]  ret_addr_q, ret_addr_d;

   logic is_ecall, is_ebreak, is_mret, int_req, trigger;

   // Decode trigger sources; an interrupt held off by a running divide simply
   // stays visible on the level input and is picked up once the divide ends.
   always_comb begin
      is_ecall  = (bus.inst_i == INST_ECALL);
      is_ebreak = (bus.inst_i == INST_EBREAK);
      is_mret   = (bus.inst_i == INST_MRET);
      int_req   = bus.int_flag_i && bus.global_int_en_i && !bus.div_started_i;
      trigger   = (state_q == S_IDLE) && (is_ecall || is_ebreak || is_mret || int_req);
   end

   // Next-state logic; cause and return address are captured only when leaving IDLE
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      ret_addr_d = ret_addr_q;
      case (state_q)
         S_IDLE: begin
            if (is_ecall || is_ebreak) begin
               state_d    = S_W_MEPC;
               cause_d    = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
               ret_addr_d = bus.inst_addr_i;
            end else if (is_mret) begin
               state_d    = S_MRET_MSTATUS;
            end else if (int_req) begin
               state_d    = S_W_MEPC;
               cause_d    = CAUSE_TIMER;
               ret_addr_d = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
            end
         end
         S_W_MEPC:       state_d = S_W_MSTATUS;
         S_W_MSTATUS:    state_d = S_W_MCAUSE;
         S_W_MCAUSE:     state_d = S_ASSERT;
         S_ASSERT:       state_d = S_IDLE;
         S_MRET_MSTATUS: state_d = S_MRET_ASSERT;
         S_MRET_ASSERT:  state_d = S_IDLE;
         default:        state_d = S_IDLE;
      endcase
   end

   // State and latch registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cause_q    <= '0;
         ret_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         ret_addr_q <= ret_addr_d;
      end
   end

   // CSR write port and redirect strobe decoded from the registered state only
   always_comb begin
      bus.we_o         = 1'b0;
      bus.waddr_o      = '0;
      bus.data_o       = '0;
      bus.int_assert_o = 1'b0;
      bus.int_addr_o   = '0;
      case (state_q)
         S_W_MEPC: begin
            bus.we_o    = 1'b1;
            bus.waddr_o = {20'd0, CSR_MEPC};
            bus.data_o  = ret_addr_q;
         end
         S_W_MSTATUS: begin
            bus.we_o    = 1'b1;
            bus.waddr_o = {20'd0, CSR_MSTATUS};
            bus.data_o  = trap_mstatus(bus.csr_mstatus_i);
         end
         S_W_MCAUSE: begin
            bus.we_o    = 1'b1;
            bus.waddr_o = {20'd0, CSR_MCAUSE};
            bus.data_o  = cause_q;
         end
         S_ASSERT: begin
            bus.int_assert_o = 1'b1;
            bus.int_addr_o   = bus.csr_mtvec_i;
         end
         S_MRET_MSTATUS: begin
            bus.we_o    = 1'b1;
            bus.waddr_o = {20'd0, CSR_MSTATUS};
            bus.data_o  = mret_mstatus(bus.csr_mstatus_i);
         end
         S_MRET_ASSERT: begin
            bus.int_assert_o = 1'b1;
            bus.int_addr_o   = bus.csr_mepc_i;
         end
         default: ;
      endcase
   end

   // Stall covers the trigger cycle itself, hence the combinational term
   always_comb begin
      bus.hold_flag_o = trigger || (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Cycle-accurate check of the trap sequencer: per-cycle vectors of inputs and
// expected outputs, pushed to a scoreboard when driven and compared mid-cycle.
module tb_clint_trap_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] EC  = 32'h0000_0073;
   localparam logic [31:0] EB  = 32'h0010_0073;
   localparam logic [31:0] MR  = 32'h3020_0073;

   typedef struct {
      logic        rst_n;
      logic        intf;
      logic        mie;
      logic        div;
      logic        jf;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] ja;
      logic [31:0] mstatus;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic        e_hold;
      logic        e_we;
      logic [31:0] e_waddr;
      logic [31:0] e_data;
      logic        e_ia;
      logic [31:0] e_iaddr;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   clint_trap_ctrl_if bus ();

   clint_trap_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic intf, input logic mie, input logic div,
                               input logic jf, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] ja, input logic [31:0] ms, input logic [31:0] mepc,
                               input logic hold, input logic we, input logic [31:0] wa,
                               input logic [31:0] wd, input logic ia, input logic [31:0] iaddr);
      vec_t v;
      v.rst_n = r; v.intf = intf; v.mie = mie; v.div = div; v.jf = jf;
      v.inst = inst; v.pc = pc; v.ja = ja; v.mstatus = ms; v.mtvec = 32'h200; v.mepc = mepc;
      v.e_hold = hold; v.e_we = we; v.e_waddr = wa; v.e_data = wd; v.e_ia = ia; v.e_iaddr = iaddr;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, req);
      end
   endtask

   // Drive one cycle of inputs just after the edge, compare outputs mid-cycle
   task automatic step(input vec_t v, input int idx);
      vec_t e;
      @(posedge clk);
      #1;
      rst                 = v.rst_n;
      bus.int_flag_i      = v.intf;
      bus.global_int_en_i = v.mie;
      bus.div_started_i   = v.div;
      bus.jump_flag_i     = v.jf;
      bus.inst_i          = v.inst;
      bus.inst_addr_i     = v.pc;
      bus.jump_addr_i     = v.ja;
      bus.csr_mstatus_i   = v.mstatus;
      bus.csr_mtvec_i     = v.mtvec;
      bus.csr_mepc_i      = v.mepc;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("hold",       idx, {31'd0, bus.hold_flag_o},  {31'd0, e.e_hold});
      chk("we",         idx, {31'd0, bus.we_o},         {31'd0, e.e_we});
      chk("waddr",      idx, bus.waddr_o,               e.e_waddr);
      chk("data",       idx, bus.data_o,                e.e_data);
      chk("int_assert", idx, {31'd0, bus.int_assert_o}, {31'd0, e.e_ia});
      chk("int_addr",   idx, bus.int_addr_o,            e.e_iaddr);
   endtask

   initial begin
      //           rst intf mie div jf inst pc        ja        mstatus   mepc      hold we waddr    data          ia iaddr
      // reset state
      vecs.push_back(mk(0, 0, 0, 0, 0, NOP, 32'h0,   32'h0,   32'h0,   32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h0));
      // ecall
      vecs.push_back(mk(1, 0, 1, 0, 0, EC,  32'h100, 32'h0,   32'h8,   32'h0,   1, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 0, 1, 0, 0, EC,  32'h100, 32'h0,   32'h8,   32'h0,   1, 1, 32'h341, 32'h100,      0, 32'h0));
      vecs.push_back(mk(1, 0, 1, 0, 0, EC,  32'h100, 32'h0,   32'h8,   32'h0,   1, 1, 32'h300, 32'h80,       0, 32'h0));
      vecs.push_back(mk(1, 0, 1, 0, 0, EC,  32'h100, 32'h0,   32'h80,  32'h100, 1, 1, 32'h342, 32'd11,       0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, EC,  32'h100, 32'h0,   32'h80,  32'h100, 1, 0, 32'h0,   32'h0,        1, 32'h200));
      vecs.push_back(mk(1, 0, 0, 0, 0, NOP, 32'h200, 32'h0,   32'h80,  32'h100, 0, 0, 32'h0,   32'h0,        0, 32'h0));
      // mret
      vecs.push_back(mk(1, 0, 0, 0, 0, MR,  32'h210, 32'h0,   32'h80,  32'h104, 1, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, MR,  32'h210, 32'h0,   32'h80,  32'h104, 1, 1, 32'h300, 32'h88,       0, 32'h0));
      vecs.push_back(mk(1, 0, 1, 0, 0, MR,  32'h210, 32'h0,   32'h88,  32'h104, 1, 0, 32'h0,   32'h0,        1, 32'h104));
      vecs.push_back(mk(1, 0, 1, 0, 0, NOP, 32'h104, 32'h0,   32'h88,  32'h104, 0, 0, 32'h0,   32'h0,        0, 32'h0));
      // interrupt while execute is jumping
      vecs.push_back(mk(1, 1, 1, 0, 1, NOP, 32'h120, 32'h340, 32'h88,  32'h104, 1, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, NOP, 32'h120, 32'h0,   32'h88,  32'h104, 1, 1, 32'h341, 32'h340,      0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, NOP, 32'h120, 32'h0,   32'h88,  32'h340, 1, 1, 32'h300, 32'h80,       0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h120, 32'h0,   32'h80,  32'h340, 1, 1, 32'h342, 32'h8000_0004, 0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h120, 32'h0,   32'h80,  32'h340, 1, 0, 32'h0,   32'h0,        1, 32'h200));
      // masked interrupt: no action
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h200, 32'h0,   32'h80,  32'h340, 0, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h204, 32'h0,   32'h80,  32'h340, 0, 0, 32'h0,   32'h0,        0, 32'h0));
      // ebreak with interrupt pending: ebreak wins
      vecs.push_back(mk(1, 1, 1, 0, 0, EB,  32'h150, 32'h0,   32'h88,  32'h340, 1, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, EB,  32'h150, 32'h0,   32'h88,  32'h340, 1, 1, 32'h341, 32'h150,      0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, EB,  32'h150, 32'h0,   32'h88,  32'h150, 1, 1, 32'h300, 32'h80,       0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, EB,  32'h150, 32'h0,   32'h80,  32'h150, 1, 1, 32'h342, 32'd3,        0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, EB,  32'h150, 32'h0,   32'h80,  32'h150, 1, 0, 32'h0,   32'h0,        1, 32'h200));
      // handler runs masked, then returns
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h200, 32'h0,   32'h80,  32'h154, 0, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, MR,  32'h204, 32'h0,   32'h80,  32'h154, 1, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, MR,  32'h204, 32'h0,   32'h80,  32'h154, 1, 1, 32'h300, 32'h88,       0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, MR,  32'h204, 32'h0,   32'h88,  32'h154, 1, 0, 32'h0,   32'h0,        1, 32'h154));
      // pending interrupt retaken after mret
      vecs.push_back(mk(1, 1, 1, 0, 0, NOP, 32'h154, 32'h0,   32'h88,  32'h154, 1, 0, 32'h0,   32'h0,        0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, NOP, 32'h154, 32'h0,   32'h88,  32'h154, 1, 1, 32'h341, 32'h154,      0, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, NOP, 32'h154, 32'h0,   32'h88,  32'h154, 1, 1, 32'h300, 32'h80,       0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h154, 32'h0,   32'h80,  32'h154, 1, 1, 32'h342, 32'h8000_0004, 0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 0, 0, NOP, 32'h154, 32'h0,   32'h80,  32'h154, 1, 0, 32'h0,   32'h0,        1, 32'h200));
      vecs.push_back(mk(1, 0, 0, 0, 0, NOP, 32'h200, 32'h0,   32'h80,  32'h154, 0, 0, 32'h0,   32'h0,        0, 32'h0));

      // Unchecked initial reset so the state is known before the first vector
      rst = 1'b0;
      bus.int_flag_i = 1'b0; bus.global_int_en_i = 1'b0; bus.div_started_i = 1'b0;
      bus.jump_flag_i = 1'b0; bus.inst_i = NOP; bus.inst_addr_i = '0; bus.jump_addr_i = '0;
      bus.csr_mstatus_i = '0; bus.csr_mtvec_i = 32'h200; bus.csr_mepc_i = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Deferred interrupt: divide busy for 5 cycles holds it off
      for (int i = 0; i < 5; i++)
         step(mk(1, 1, 1, 1, 0, NOP, 32'h180, 32'h0, 32'h88, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0), 100 + i);
      step(mk(1, 1, 1, 0, 0, NOP, 32'h180, 32'h0, 32'h88, 32'h0, 1, 0, 32'h0,   32'h0,   0, 32'h0), 105);
      step(mk(1, 1, 1, 0, 0, NOP, 32'h180, 32'h0, 32'h88, 32'h0, 1, 1, 32'h341, 32'h180, 0, 32'h0), 106);
      step(mk(1, 1, 1, 0, 0, NOP, 32'h180, 32'h0, 32'h88, 32'h0, 1, 1, 32'h300, 32'h80,  0, 32'h0), 107);
      step(mk(1, 1, 0, 0, 0, NOP, 32'h180, 32'h0, 32'h80, 32'h0, 1, 1, 32'h342, 32'h8000_0004, 0, 32'h0), 108);
      step(mk(1, 1, 0, 0, 0, NOP, 32'h180, 32'h0, 32'h80, 32'h0, 1, 0, 32'h0,   32'h0,   1, 32'h200), 109);
      step(mk(1, 0, 0, 0, 0, NOP, 32'h200, 32'h0, 32'h80, 32'h0, 0, 0, 32'h0,   32'h0,   0, 32'h0), 110);

      // Reset asserted during W_MSTATUS: sequence abandoned, no redirect
      step(mk(1, 0, 1, 0, 0, EC,  32'h300, 32'h0, 32'h8,  32'h0, 1, 0, 32'h0,   32'h0,   0, 32'h0), 200);
      step(mk(1, 0, 1, 0, 0, EC,  32'h300, 32'h0, 32'h8,  32'h0, 1, 1, 32'h341, 32'h300, 0, 32'h0), 201);
      step(mk(0, 0, 1, 0, 0, NOP, 32'h300, 32'h0, 32'h8,  32'h0, 1, 1, 32'h300, 32'h80,  0, 32'h0), 202);
      for (int i = 0; i < 4; i++)
         step(mk(1, 0, 1, 0, 0, NOP, 32'h300, 32'h0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0), 203 + i);

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
